imem_arbiter: RTL and testbench

- Shares the single-port, 512x32 synchronous instruction memory between the pipeline fetch stage and the program loader.
- Provides a BOOT phase after reset in which the loader has exclusive access, so a program can be written in.
- Provides a RUN phase in which fetch has priority and loader accesses are bounded by a starvation counter.
- Tracks the memory's 1-cycle registered read latency and returns read data and valid to whichever requester issued the read.

---
 rtl/imem_arbiter_if.sv | 48 ++++
 rtl/imem_arbiter.sv | 112 +++++++++++
 tb/tb_imem_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and memory-side signals of the imem arbiter.
// slave = arbiter side, master = requesters/memory side.
interface imem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              halt;
  logic              l_done;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_wea;
  logic [DATA_W-1:0] mem_dout;
  logic              state_run;

  modport slave (
    input  halt, l_done,
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_addr, mem_din, mem_wea,
    input  mem_dout,
    output state_run
  );

  modport master (
    output halt, l_done,
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_addr, mem_din, mem_wea,
    output mem_dout,
    input  state_run
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction memory between fetch and loader.
// Define IMEM_ARB_STATS_EN for fetch-stall and loader-write counters.
module imem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  imem_arbiter_if.slave bus
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0] fetch_stall_cnt,
  output logic [31:0] load_wr_cnt
`endif
);

  typedef enum logic {
    S_BOOT,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_F,
    OWN_L
  } own_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t            state, state_n;
  own_t              owner, owner_n;
  logic [3:0]        starve, starve_n;
  logic              f_g, l_g;
  logic              f_gq, l_gq;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_BOOT;
      owner  <= OWN_NONE;
      starve <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      starve <= starve_n;
    end
  end

  always_comb begin
    state_n  = state;
    starve_n = '0;
    f_g      = 1'b0;
    l_g      = 1'b0;
    if (state == S_BOOT) begin
      l_g = bus.l_req;
      if (bus.l_done) state_n = S_RUN;
    end else begin
      if (bus.f_req && (starve < SMAX)) f_g = 1'b1;
      else l_g = bus.l_req;
      if (bus.l_req && !l_g) starve_n = starve + 4'd1;
      if (bus.halt) begin
        state_n  = S_BOOT;
        starve_n = '0;
      end
    end
  end

  // grants are forced low for as long as reset is held
  assign f_gq = f_g & ~rst;
  assign l_gq = l_g & ~rst;

  always_comb begin
    owner_n = OWN_NONE;
    unique case (1'b1)
      f_gq:              owner_n = OWN_F;
      l_gq & ~bus.l_we:  owner_n = OWN_L;
      default:           owner_n = OWN_NONE;
    endcase
  end

  assign addr_sel = l_gq ? bus.l_addr : bus.f_addr;
  assign rdata    = bus.mem_dout;

  assign bus.f_gnt     = f_gq;
  assign bus.l_gnt     = l_gq;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_din   = bus.l_wdata;
  assign bus.mem_wea   = l_gq & bus.l_we;
  assign bus.f_rvalid  = (owner == OWN_F);
  assign bus.l_rvalid  = (owner == OWN_L);
  assign bus.f_rdata   = rdata;
  assign bus.l_rdata   = rdata;
  assign bus.state_run = (state == S_RUN);

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_stall_cnt <= '0;
      load_wr_cnt     <= '0;
    end else begin
      if ((state == S_RUN) && bus.f_req && !f_gq
          && (fetch_stall_cnt != '1))
        fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
      if (l_gq && bus.l_we && (load_wr_cnt != '1))
        load_wr_cnt <= load_wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios with a read-data scoreboard.
// Expected read data is queued at grant time and popped on rvalid.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] f_q[$];
  logic [31:0] l_q[$];
  logic [31:0] mem [512];
  bit          init_done = 1'b0;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] fsc, lwc;
`endif

  imem_arbiter_if bus ();

  imem_arbiter #(
    .ADDR_W(9),
    .DATA_W(32),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IMEM_ARB_STATS_EN
    ,
    .fetch_stall_cnt(fsc),
    .load_wr_cnt(lwc)
`endif
  );

  always #5 clk = ~clk;

  // synchronous 512x32 memory, preloaded with A500_0000 | addr
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      init_done <= 1'b1;
    end else begin
      if (bus.mem_wea) mem[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= mem[bus.mem_addr];
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.f_rvalid) begin
      if (f_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL f_rvalid_unexpected actual=1 required=0");
      end else chk("f_rdata", bus.f_rdata, f_q.pop_front());
    end
    if (bus.l_rvalid) begin
      if (l_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL l_rvalid_unexpected actual=1 required=0");
      end else chk("l_rdata", bus.l_rdata, l_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.halt    = 1'b0;
    bus.l_done  = 1'b0;
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
  endtask

  task automatic boot_wr(input logic [8:0] a, input logic [31:0] d,
                         input logic done);
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = a;
    bus.l_wdata = d;
    bus.l_done  = done;
    bus.f_req   = 1'b1;
    bus.f_addr  = 9'd1;
    @(negedge clk);
    chk("boot_l_gnt", 32'(bus.l_gnt), 32'd1);
    chk("boot_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("boot_wea", 32'(bus.mem_wea), 32'd1);
    chk("boot_mem_addr", 32'(bus.mem_addr), 32'(a));
    chk("boot_state_run", 32'(bus.state_run), 32'd0);
    tick();
  endtask

  localparam logic [5:0] EXP_F = 6'b101111;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.f_req = 1'b1;
    bus.l_req = 1'b1;
    bus.l_we  = 1'b1;
    @(negedge clk);
    chk("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("rst_l_gnt", 32'(bus.l_gnt), 32'd0);
    chk("rst_wea", 32'(bus.mem_wea), 32'd0);
    chk("rst_state_run", 32'(bus.state_run), 32'd0);
    tick();
    rst = 1'b0;
    idle();

    boot_wr(9'd0, 32'hE3A0_0001, 1'b0);
    boot_wr(9'd1, 32'hE280_0001, 1'b0);
    boot_wr(9'd2, 32'hEAFF_FFFE, 1'b1);
    idle();
    bus.f_req  = 1'b1;
    bus.f_addr = 9'd1;
    @(negedge clk);
    chk("run_state_run", 32'(bus.state_run), 32'd1);
    chk("run_f_gnt", 32'(bus.f_gnt), 32'd1);
    f_q.push_back(32'hE280_0001);
    tick();
    idle();
    @(negedge clk);
    chk("run_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    tick();

    for (int i = 0; i < 6; i++) begin
      bus.f_req  = 1'b1;
      bus.f_addr = 9'd0;
      bus.l_req  = (i < 5);
      bus.l_we   = 1'b0;
      bus.l_addr = 9'd5;
      @(negedge clk);
      chk($sformatf("starve_f_gnt%0d", i), 32'(bus.f_gnt),
          32'(EXP_F[i]));
      chk($sformatf("starve_l_gnt%0d", i), 32'(bus.l_gnt),
          (i == 4) ? 32'd1 : 32'd0);
      if (EXP_F[i]) f_q.push_back(32'hE3A0_0001);
      if (i == 4) l_q.push_back(32'hA500_0005);
      if (i == 5) chk("starve_l_rvalid", 32'(bus.l_rvalid), 32'd1);
      tick();
    end
    idle();
    @(negedge clk);
`ifdef IMEM_ARB_STATS_EN
    chk("stats_stall", fsc, 32'd1);
    chk("stats_wr", lwc, 32'd3);
`endif
    tick();

    bus.f_req  = 1'b1;
    bus.f_addr = 9'd2;
    @(negedge clk);
    chk("mid_f_gnt", 32'(bus.f_gnt), 32'd1);
    tick();
    rst = 1'b1;
    bus.l_req = 1'b1;
    bus.l_we  = 1'b1;
    @(negedge clk);
    chk("mid_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    chk("mid_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    chk("mid_f_gnt_rst", 32'(bus.f_gnt), 32'd0);
    chk("mid_l_gnt_rst", 32'(bus.l_gnt), 32'd0);
    chk("mid_wea", 32'(bus.mem_wea), 32'd0);
    chk("mid_state_run", 32'(bus.state_run), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    bus.f_req = 1'b1;
    @(negedge clk);
    chk("reboot_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("reboot_state_run", 32'(bus.state_run), 32'd0);
`ifdef IMEM_ARB_STATS_EN
    chk("reboot_stall", fsc, 32'd0);
    chk("reboot_wr", lwc, 32'd0);
`endif
    tick();
    idle();
    bus.l_done = 1'b1;
    tick();

    idle();
    bus.halt   = 1'b1;
    bus.f_req  = 1'b1;
    bus.f_addr = 9'd2;
    @(negedge clk);
    chk("halt_state_run", 32'(bus.state_run), 32'd1);
    chk("halt_f_gnt", 32'(bus.f_gnt), 32'd1);
    f_q.push_back(32'hEAFF_FFFE);
    tick();
    bus.halt = 1'b0;
    @(negedge clk);
    chk("halt_state_boot", 32'(bus.state_run), 32'd0);
    chk("halt_f_gnt_after", 32'(bus.f_gnt), 32'd0);
    chk("halt_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    tick();

    idle();
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 9'd511;
    bus.l_wdata = 32'hDEAD_BEEF;
    bus.l_done  = 1'b1;
    @(negedge clk);
    chk("wr511_l_gnt", 32'(bus.l_gnt), 32'd1);
    chk("wr511_mem_addr", 32'(bus.mem_addr), 32'd511);
    tick();
    idle();
    bus.f_req  = 1'b1;
    bus.f_addr = 9'd511;
    @(negedge clk);
    chk("rd511_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("rd511_mem_addr", 32'(bus.mem_addr), 32'd511);
    f_q.push_back(32'hDEAD_BEEF);
    tick();
    idle();
    @(negedge clk);
    chk("rd511_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    tick();
    @(negedge clk);
    chk("f_q_empty", 32'(f_q.size()), 32'd0);
    chk("l_q_empty", 32'(l_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
